key_cursor_ctrl: RTL and testbench
==================================

KEY_CURSOR_CTRL -- requirements
Module: key_cursor_ctrl

Interface
REQ-001 Parameter CELL_W, default 40: horizontal cursor step in pixels.
REQ-002 Parameter CELL_H, default 40: vertical cursor step in pixels.
REQ-003 Parameter MAX_X, default 600: largest legal ocur_x; a multiple of CELL_W.
REQ-004 Parameter MAX_Y, default 440: largest legal ocur_y; a multiple of CELL_H.
REQ-005 iCLK  input  1  single clock; all logic on its rising edge.
REQ-006 iRST  input  1  reset, synchronous, active-high.
REQ-007 iscan  input  8  PS/2 scan-code byte, set-2 encoding.
REQ-008 iscan_valid  input  1  iscan is valid this cycle; one byte per asserted cycle.
REQ-009 oascii  output  8  ASCII code of the last accepted character key, feeding the digit renderer.
REQ-010 ocur_x  output  10  cursor cell origin X in pixels.
REQ-011 ocur_y  output  10  cursor cell origin Y in pixels.
REQ-012 okey_strobe  output  1  one-cycle pulse when oascii or the cursor changes due to a key.

Function
REQ-013 The FSM SHALL have states IDLE, BRK, EXT and EXT_BRK, and SHALL act only on cycles with iscan_valid=1.
REQ-014 In IDLE: 0xF0 -> BRK; 0xE0 -> EXT; any other byte is a make code, decoded per REQ-016/017, and the FSM stays in IDLE.
REQ-015 BRK: next byte is discarded (key release) -> IDLE; EXT: 0xF0 -> EXT_BRK, 0xE0 -> EXT, else decode extended make -> IDLE; EXT_BRK: next byte discarded -> IDLE.
REQ-016 Digit makes 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 SHALL set oascii to 0x30..0x39 respectively and advance the cursor one cell right.
REQ-017 Backspace make 0x66 SHALL move the cursor one cell left and set oascii to 0x20; unlisted make codes SHALL be ignored, with no strobe.
REQ-018 Extended makes 0x75/0x72/0x6B/0x74 SHALL move the cursor up/down/left/right by one cell and leave oascii unchanged; other extended codes SHALL be ignored.
REQ-019 Outputs SHALL update on the clock edge following the iscan_valid cycle (latency 1), with okey_strobe high for exactly that one cycle.
REQ-020 Cursor arithmetic SHALL be 10-bit unsigned, and the cursor SHALL never hold a value outside 0..MAX_X or 0..MAX_Y.
REQ-021 Typematic repeats (repeated makes without a break) SHALL each be acted on as a new key.

Reset
REQ-022 While iRST=1 at a clock edge: state=IDLE, oascii=0x30, ocur_x=0, ocur_y=0, okey_strobe=0.
REQ-023 Reset asserted mid-sequence (BRK/EXT/EXT_BRK) SHALL abandon the sequence, and the next byte after reset SHALL be treated as starting in IDLE.

Configuration
REQ-024 With KEY_CURSOR_WRAP_EN defined, moves past an edge SHALL wrap: right from MAX_X -> x=0 and y+CELL_H (y wrapping MAX_Y -> 0); left from 0 -> x=MAX_X and y-CELL_H (y wrapping 0 -> MAX_Y); up/down wrap y only.
REQ-025 Without KEY_CURSOR_WRAP_EN, moves past an edge SHALL saturate at 0 or MAX, while still updating oascii and still pulsing okey_strobe.

Structure
REQ-026 Package key_cursor_pkg SHALL hold the FSM state enum, scan-code constants (0xE0, 0xF0, digit, backspace and arrow codes) and the default cell/limit constants.
REQ-027 The scan-to-ASCII lookup SHALL be the sub-module key_scan_decode (combinational, outputs: hit flag, ASCII value, move direction); key_cursor_ctrl holds the FSM and cursor registers.

Verification
REQ-028 Reset, then bytes 0x1E -> oascii=0x32, ocur_x=40, ocur_y=0, one strobe pulse; then 0xF0,0x1E -> no output change, no strobe.
REQ-029 E0,72 then E0,F0,72 -> ocur_y=40 after the first pair only; E0,74 -> ocur_x+40, oascii unchanged.
REQ-030 Cursor at (600,0), byte 0x16 -> wrap build: (0,40), oascii=0x31; non-wrap build: (600,0), oascii=0x31, strobe pulses.
REQ-031 Cursor at (0,0), E0,75 then 0x66 -> wrap build: (0,440) then (600,400), oascii=0x20; non-wrap build: stays (0,0).
REQ-032 Send 0xE0, assert iRST one cycle, then send 0x74 -> treated as plain make 0x74: ignored, no move, no strobe; outputs at reset values.
REQ-033 Bytes 0x12 (unlisted) and E0,0x11 (unlisted extended) -> no output change, no strobe, FSM back in IDLE (verified by a following 0x45 giving oascii=0x30).

Source files
------------

// File: rtl/key_cursor_pkg.sv
// key_cursor_pkg
// Shared types and constants for the keyboard-driven cursor controller:
//   - PS/2 set-2 scan codes for prefixes, digits, backspace and arrows
//   - ASCII values produced by the decoder
//   - default cell size and cursor limits
//   - receive FSM state enum and cursor move enum
package key_cursor_pkg;

    // Default geometry: 40x40 cells, cursor origin limited to 0..600 / 0..440
    localparam int unsigned CELL_W_DEF = 40;
    localparam int unsigned CELL_H_DEF = 40;
    localparam int unsigned MAX_X_DEF  = 600;
    localparam int unsigned MAX_Y_DEF  = 440;

    // Prefix bytes
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Digit make codes, '0'..'9'
    localparam logic [7:0] SC_D0 = 8'h45;
    localparam logic [7:0] SC_D1 = 8'h16;
    localparam logic [7:0] SC_D2 = 8'h1E;
    localparam logic [7:0] SC_D3 = 8'h26;
    localparam logic [7:0] SC_D4 = 8'h25;
    localparam logic [7:0] SC_D5 = 8'h2E;
    localparam logic [7:0] SC_D6 = 8'h36;
    localparam logic [7:0] SC_D7 = 8'h3D;
    localparam logic [7:0] SC_D8 = 8'h3E;
    localparam logic [7:0] SC_D9 = 8'h46;

    localparam logic [7:0] SC_BKSP = 8'h66;

    // Extended (E0-prefixed) arrow make codes
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        StIdle,
        StBrk,
        StExt,
        StExtBrk
    } kc_state_e;

    typedef enum logic [2:0] {
        MvNone,
        MvUp,
        MvDown,
        MvLeft,
        MvRight
    } kc_move_e;

endpackage

// File: rtl/key_scan_decode.sv
// key_scan_decode
// Combinational scan-code lookup for the cursor controller.
// Ports:
//   iscan      in   8  make-code byte (prefixes already stripped)
//   iext       in   1  byte followed an E0 prefix
//   ohit       out  1  byte is a recognised key
//   oascii_we  out  1  key carries a character (arrows do not)
//   oascii     out  8  character for the key when oascii_we=1
//   omove      out     cursor move requested by the key
module key_scan_decode
    import key_cursor_pkg::*;
(
    input  logic [7:0] iscan,
    input  logic       iext,
    output logic       ohit,
    output logic       oascii_we,
    output logic [7:0] oascii,
    output kc_move_e   omove
);

    always_comb begin
        ohit      = 1'b0;
        oascii_we = 1'b0;
        oascii    = ASCII_ZERO;
        omove     = MvNone;
        if (iext) begin
            ohit = 1'b1;
            case (iscan)
                SC_UP:    omove = MvUp;
                SC_DOWN:  omove = MvDown;
                SC_LEFT:  omove = MvLeft;
                SC_RIGHT: omove = MvRight;
                default:  ohit  = 1'b0;
            endcase
        end else begin
            ohit      = 1'b1;
            oascii_we = 1'b1;
            omove     = MvRight;
            case (iscan)
                SC_D0:   oascii = 8'h30;
                SC_D1:   oascii = 8'h31;
                SC_D2:   oascii = 8'h32;
                SC_D3:   oascii = 8'h33;
                SC_D4:   oascii = 8'h34;
                SC_D5:   oascii = 8'h35;
                SC_D6:   oascii = 8'h36;
                SC_D7:   oascii = 8'h37;
                SC_D8:   oascii = 8'h38;
                SC_D9:   oascii = 8'h39;
                SC_BKSP: begin
                    oascii = ASCII_SPACE;
                    omove  = MvLeft;
                end
                default: begin
                    ohit      = 1'b0;
                    oascii_we = 1'b0;
                    omove     = MvNone;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_cursor_ctrl.sv
// key_cursor_ctrl
// Turns a stream of PS/2 set-2 scan bytes into a character code and a
// cell-aligned text cursor. Digits type a character and advance right,
// backspace blanks and steps left, E0-prefixed arrows move the cursor.
// Break sequences (F0 xx, E0 F0 xx) are swallowed.
// Configuration macro: KEY_CURSOR_WRAP_EN -- when defined, moves past an edge
// wrap around the screen; otherwise they saturate at the edge.
// Ports:
//   iCLK         in   1   clock, rising edge
//   iRST         in   1   synchronous active-high reset
//   iscan        in   8   scan-code byte
//   iscan_valid  in   1   iscan valid this cycle
//   oascii       out  8   last accepted character
//   ocur_x       out  10  cursor cell origin X (pixels)
//   ocur_y       out  10  cursor cell origin Y (pixels)
//   okey_strobe  out  1   one-cycle pulse per acted-on key
module key_cursor_ctrl
    import key_cursor_pkg::*;
#(
    parameter int unsigned CELL_W = CELL_W_DEF,
    parameter int unsigned CELL_H = CELL_H_DEF,
    parameter int unsigned MAX_X  = MAX_X_DEF,
    parameter int unsigned MAX_Y  = MAX_Y_DEF
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iscan,
    input  logic       iscan_valid,
    output logic [7:0] oascii,
    output logic [9:0] ocur_x,
    output logic [9:0] ocur_y,
    output logic       okey_strobe
);

    localparam logic [9:0] STEP_X = 10'(CELL_W);
    localparam logic [9:0] STEP_Y = 10'(CELL_H);
    localparam logic [9:0] LIM_X  = 10'(MAX_X);
    localparam logic [9:0] LIM_Y  = 10'(MAX_Y);

`ifdef KEY_CURSOR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    kc_state_e  state_q, state_d;
    logic [7:0] ascii_q, ascii_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       strobe_q, strobe_d;
    logic       act;

    logic       dec_hit;
    logic       dec_ascii_we;
    logic [7:0] dec_ascii;
    kc_move_e   dec_move;

    key_scan_decode u_decode (
        .iscan     (iscan),
        .iext      (state_q == StExt),
        .ohit      (dec_hit),
        .oascii_we (dec_ascii_we),
        .oascii    (dec_ascii),
        .omove     (dec_move)
    );

    always_comb begin
        state_d  = state_q;
        ascii_d  = ascii_q;
        x_d      = x_q;
        y_d      = y_q;
        strobe_d = 1'b0;
        act      = 1'b0;

        if (iscan_valid) begin
            case (state_q)
                StIdle: begin
                    if (iscan == SC_BRK) begin
                        state_d = StBrk;
                    end else if (iscan == SC_EXT) begin
                        state_d = StExt;
                    end else begin
                        act = 1'b1;
                    end
                end
                StExt: begin
                    if (iscan == SC_BRK) begin
                        state_d = StExtBrk;
                    end else if (iscan != SC_EXT) begin
                        // A repeated E0 keeps us waiting for the real code
                        act     = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle; // released key code, dropped
            endcase
        end

        if (act && dec_hit) begin
            strobe_d = 1'b1;
            if (dec_ascii_we) begin
                ascii_d = dec_ascii;
            end
            case (dec_move)
                MvRight: begin
                    if (x_q >= LIM_X) begin
                        if (WRAP_EN) begin
                            x_d = '0;
                            y_d = (y_q >= LIM_Y) ? '0 : y_q + STEP_Y;
                        end
                    end else begin
                        x_d = x_q + STEP_X;
                    end
                end
                MvLeft: begin
                    if (x_q == '0) begin
                        if (WRAP_EN) begin
                            x_d = LIM_X;
                            y_d = (y_q == '0) ? LIM_Y : y_q - STEP_Y;
                        end
                    end else begin
                        x_d = x_q - STEP_X;
                    end
                end
                MvUp: begin
                    if (y_q == '0) begin
                        if (WRAP_EN) begin
                            y_d = LIM_Y;
                        end
                    end else begin
                        y_d = y_q - STEP_Y;
                    end
                end
                MvDown: begin
                    if (y_q >= LIM_Y) begin
                        if (WRAP_EN) begin
                            y_d = '0;
                        end
                    end else begin
                        y_d = y_q + STEP_Y;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= StIdle;
            ascii_q  <= ASCII_ZERO;
            x_q      <= '0;
            y_q      <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ascii_q  <= ascii_d;
            x_q      <= x_d;
            y_q      <= y_d;
            strobe_q <= strobe_d;
        end
    end

    assign oascii      = ascii_q;
    assign ocur_x      = x_q;
    assign ocur_y      = y_q;
    assign okey_strobe = strobe_q;

endmodule

// File: tb/tb_key_cursor_ctrl.sv
// tb_key_cursor_ctrl
// Self-checking bench for key_cursor_ctrl: a table of per-cycle vectors,
// hand-written edge sequences, then random byte streams against a
// cell-index reference model.
module tb_key_cursor_ctrl;

    localparam int CW    = 40;
    localparam int CH    = 40;
    localparam int MX    = 600;
    localparam int MY    = 440;
    localparam int COLS  = MX / CW + 1;
    localparam int ROWS  = MY / CH + 1;
    localparam int NCELL = COLS * ROWS;

    logic       iCLK;
    logic       iRST;
    logic [7:0] iscan;
    logic       iscan_valid;
    logic [7:0] oascii;
    logic [9:0] ocur_x;
    logic [9:0] ocur_y;
    logic       okey_strobe;

    key_cursor_ctrl #(
        .CELL_W (CW),
        .CELL_H (CH),
        .MAX_X  (MX),
        .MAX_Y  (MY)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iscan       (iscan),
        .iscan_valid (iscan_valid),
        .oascii      (oascii),
        .ocur_x      (ocur_x),
        .ocur_y      (ocur_y),
        .okey_strobe (okey_strobe)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_vec;
    int n_bad;

    // Reference model: pending-prefix flags plus character and cell position
    bit         m_brk;
    bit         m_ext;
    logic [7:0] m_ascii;
    int         m_x;
    int         m_y;
    bit         m_strobe;
    logic [7:0] digit_codes [10];

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] sc;
        logic [7:0] a;
        logic [9:0] x;
        logic [9:0] y;
        logic       s;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic [7:0] sc,
                       input logic [7:0] a, input int x, input int y, input logic s);
        vec_t e;
        e.rst = r; e.vld = v; e.sc = sc; e.a = a;
        e.x = 10'(x); e.y = 10'(y); e.s = s;
        tbl.push_back(e);
    endtask

    task automatic move(input int dx, input int dy);
        int idx;
`ifdef KEY_CURSOR_WRAP_EN
        if (dx != 0) begin
            idx = (m_y / CH) * COLS + m_x / CW + dx;
            idx = (idx + NCELL) % NCELL;
            m_x = (idx % COLS) * CW;
            m_y = (idx / COLS) * CH;
        end
        if (dy != 0) m_y = (((m_y / CH) + dy + ROWS) % ROWS) * CH;
`else
        idx = 0;
        m_x = m_x + dx * CW;
        m_y = m_y + dy * CH;
        if (m_x < 0) m_x = 0;
        if (m_x > MX) m_x = MX;
        if (m_y < 0) m_y = 0;
        if (m_y > MY) m_y = MY;
`endif
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] sc);
        m_strobe = 1'b0;
        if (r) begin
            m_brk = 0; m_ext = 0; m_ascii = 8'h30; m_x = 0; m_y = 0;
        end else if (v) begin
            if (m_brk) begin
                m_brk = 0;
                m_ext = 0;
            end else if (sc == 8'hF0) begin
                m_brk = 1;
                m_ext = 0;
            end else if (sc == 8'hE0) begin
                m_ext = 1;
            end else if (m_ext) begin
                m_ext = 0;
                m_strobe = 1'b1;
                case (sc)
                    8'h75: move(0, -1);
                    8'h72: move(0, 1);
                    8'h6B: move(-1, 0);
                    8'h74: move(1, 0);
                    default: m_strobe = 1'b0;
                endcase
            end else if (sc == 8'h66) begin
                m_strobe = 1'b1;
                m_ascii = 8'h20;
                move(-1, 0);
            end else begin
                for (int i = 0; i < 10; i++) begin
                    if (digit_codes[i] == sc) begin
                        m_strobe = 1'b1;
                        m_ascii = 8'h30 + 8'(i);
                        move(1, 0);
                    end
                end
            end
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic [7:0] sc);
        @(negedge iCLK);
        iRST = r;
        iscan_valid = v;
        iscan = sc;
        model_step(r, v, sc);
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] ea, input logic [9:0] ex,
                       input logic [9:0] ey, input logic es);
        n_vec++;
        if (oascii !== ea || ocur_x !== ex || ocur_y !== ey || okey_strobe !== es) begin
            n_bad++;
            $display("FAIL %s: got ascii=%h x=%0d y=%0d strobe=%b, need ascii=%h x=%0d y=%0d strobe=%b",
                     name, oascii, ocur_x, ocur_y, okey_strobe, ea, ex, ey, es);
        end
    endtask

    task automatic chk_model(input string name);
        chk(name, m_ascii, 10'(m_x), 10'(m_y), m_strobe);
    endtask

    initial begin
        logic       r, v;
        logic [7:0] sc;
        int         k;

        n_vec = 0;
        n_bad = 0;
        digit_codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        iRST = 1'b1;
        iscan_valid = 1'b0;
        iscan = 8'h00;

        // Build-independent per-cycle vectors (cursor stays off the edges)
        add(1, 0, 8'h00, 8'h30,   0,  0, 0);  // reset values
        add(0, 1, 8'h1E, 8'h32,  40,  0, 1);  // digit '2'
        add(0, 0, 8'h00, 8'h32,  40,  0, 0);  // strobe is one cycle
        add(0, 1, 8'hF0, 8'h32,  40,  0, 0);
        add(0, 1, 8'h1E, 8'h32,  40,  0, 0);  // release ignored
        add(0, 1, 8'hE0, 8'h32,  40,  0, 0);
        add(0, 1, 8'h72, 8'h32,  40, 40, 1);  // down
        add(0, 1, 8'hE0, 8'h32,  40, 40, 0);
        add(0, 1, 8'hF0, 8'h32,  40, 40, 0);
        add(0, 1, 8'h72, 8'h32,  40, 40, 0);  // extended release ignored
        add(0, 1, 8'hE0, 8'h32,  40, 40, 0);
        add(0, 1, 8'h74, 8'h32,  80, 40, 1);  // right, ascii kept
        add(0, 1, 8'h12, 8'h32,  80, 40, 0);  // unlisted make
        add(0, 1, 8'hE0, 8'h32,  80, 40, 0);
        add(0, 1, 8'h11, 8'h32,  80, 40, 0);  // unlisted extended
        add(0, 1, 8'h45, 8'h30, 120, 40, 1);  // back in idle
        add(0, 1, 8'hE0, 8'h30, 120, 40, 0);
        add(1, 1, 8'hF0, 8'h30,   0,  0, 0);  // reset mid-sequence wins
        add(0, 1, 8'h74, 8'h30,   0,  0, 0);  // plain 0x74: ignored
        add(0, 1, 8'h46, 8'h39,  40,  0, 1);
        add(0, 1, 8'hE0, 8'h39,  40,  0, 0);
        add(0, 1, 8'hE0, 8'h39,  40,  0, 0);  // repeated prefix
        add(0, 1, 8'h72, 8'h39,  40, 40, 1);
        add(0, 1, 8'h3D, 8'h37,  80, 40, 1);  // typematic repeats
        add(0, 1, 8'h3D, 8'h37, 120, 40, 1);
        add(0, 1, 8'h3D, 8'h37, 160, 40, 1);
        add(0, 1, 8'hE0, 8'h37, 160, 40, 0);
        add(0, 1, 8'h6B, 8'h37, 120, 40, 1);  // left
        add(0, 1, 8'hE0, 8'h37, 120, 40, 0);
        add(0, 1, 8'h75, 8'h37, 120,  0, 1);  // up
        add(0, 1, 8'h66, 8'h20,  80,  0, 1);  // backspace

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].vld, tbl[i].sc);
            chk($sformatf("table%0d", i), tbl[i].a, tbl[i].x, tbl[i].y, tbl[i].s);
        end

        // Right edge: walk to x=600, then one more digit
        apply(1, 0, 8'h00);
        repeat (15) apply(0, 1, 8'h45);
        chk("walk_to_edge", 8'h30, 10'd600, 10'd0, 1'b1);
        apply(0, 1, 8'h16);
`ifdef KEY_CURSOR_WRAP_EN
        chk("right_edge", 8'h31, 10'd0, 10'd40, 1'b1);
`else
        chk("right_edge", 8'h31, 10'd600, 10'd0, 1'b1);
`endif
        apply(0, 0, 8'h00);
`ifdef KEY_CURSOR_WRAP_EN
        chk("right_edge_idle", 8'h31, 10'd0, 10'd40, 1'b0);
`else
        chk("right_edge_idle", 8'h31, 10'd600, 10'd0, 1'b0);
`endif

        // Top-left corner: up, then backspace
        apply(1, 0, 8'h00);
        apply(0, 1, 8'hE0);
        apply(0, 1, 8'h75);
`ifdef KEY_CURSOR_WRAP_EN
        chk("up_edge", 8'h30, 10'd0, 10'd440, 1'b1);
`else
        chk("up_edge", 8'h30, 10'd0, 10'd0, 1'b1);
`endif
        apply(0, 1, 8'h66);
`ifdef KEY_CURSOR_WRAP_EN
        chk("left_edge", 8'h20, 10'd600, 10'd400, 1'b1);
`else
        chk("left_edge", 8'h20, 10'd0, 10'd0, 1'b1);
`endif

        // Random byte streams against the model
        apply(1, 0, 8'h00);
        chk_model("rand_reset");
        for (int i = 0; i < 4000; i++) begin
            k = int'($urandom_range(0, 15));
            if (k < 4)        sc = digit_codes[$urandom_range(0, 9)];
            else if (k == 4)  sc = 8'h66;
            else if (k == 5)  sc = 8'h75;
            else if (k == 6)  sc = 8'h72;
            else if (k == 7)  sc = ($urandom_range(0, 1) == 0) ? 8'h6B : 8'h74;
            else if (k < 10)  sc = 8'hE0;
            else if (k < 12)  sc = 8'hF0;
            else              sc = 8'($urandom);
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 299) == 0);
            apply(r, v, sc);
            chk_model($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
